// File: rtl/mseq_burst_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mseq_pkg
// Shared types and constants for the m-sequence burst sequencer.
//   mseq_state_e   : controller states (IDLE, RUN, DONE)
//   MSEQ_POLY_DEF  : default feedback polynomial, x^8+x^4+x^3+x^2+1 (W+1 bits)
//   MANCH_LOW_HIGH : Manchester polarity, 1 = a '1' bit is sent low then high
// No ports.
// -----------------------------------------------------------------------------
package mseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mseq_state_e;

  localparam logic [8:0] MSEQ_POLY_DEF = 9'h11D;

  localparam logic MANCH_LOW_HIGH = 1'b1;

endpackage

// File: rtl/mseq_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// mseq_burst_ctrl_if
// Control/status bundle between the host (master) and the burst sequencer
// (slave).
//   start, abort          : host -> sequencer requests
//   div, len, seed        : burst configuration (half-bit divider, bits, seed)
//   manch_en              : 1 = Manchester line coding, 0 = NRZ
//   busy, done, err       : handshake status from the sequencer
//   bit_out, bit_valid    : current sequence bit and its bit-period strobe
//   line_out              : encoded line toward the driver
//   sreg                  : LFSR state
// -----------------------------------------------------------------------------
interface mseq_burst_ctrl_if #(
  parameter int W     = 8,
  parameter int DIV_W = 16,
  parameter int LEN_W = 12
) ();

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic [LEN_W-1:0] len;
  logic [W-1:0]     seed;
  logic             manch_en;
  logic             busy;
  logic             done;
  logic             err;
  logic             bit_out;
  logic             bit_valid;
  logic             line_out;
  logic [W-1:0]     sreg;

  modport master (
    output start, abort, div, len, seed, manch_en,
    input  busy, done, err, bit_out, bit_valid, line_out, sreg
  );

  modport slave (
    input  start, abort, div, len, seed, manch_en,
    output busy, done, err, bit_out, bit_valid, line_out, sreg
  );

endinterface

// File: rtl/mseq_burst_ctrl_lfsr.sv
// -----------------------------------------------------------------------------
// mseq_lfsr_core
// Right-shift Galois LFSR with parallel load. Load has priority over step.
//   clk      in  clock
//   arst     in  asynchronous active-low reset (state returns to 1)
//   load     in  load load_val into the register
//   load_val in  value to load (W bits)
//   step     in  advance the sequence by one bit
//   state    out current LFSR state (W bits)
// -----------------------------------------------------------------------------
module mseq_lfsr_core
  import mseq_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W:0] POLY = MSEQ_POLY_DEF
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  // The x^W term is implicit in a right-shift Galois register; bit 0 of POLY
  // is the feedback itself, so the XOR mask is POLY without its LSB.
  localparam logic [W-1:0] TAPS      = POLY[W:1];
  localparam logic [W-1:0] RESET_VAL = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] state_r;

  function automatic logic [W-1:0] galois_step(input logic [W-1:0] s);
    logic [W-1:0] nxt;
    nxt = {1'b0, s[W-1:1]};
    if (s[0]) begin
      nxt = nxt ^ TAPS;
    end
    return nxt;
  endfunction

  // LFSR state register: reset, load, step or hold
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_r <= RESET_VAL;
    end else if (load) begin
      state_r <= load_val;
    end else if (step) begin
      state_r <= galois_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/mseq_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mseq_burst_ctrl
// Burst sequencer for the Galois m-sequence generator: loads a seed, paces the
// LFSR at a programmable bit rate and sends a burst of len bits as NRZ or
// Manchester. Configuration is latched on a valid start and held for the
// whole burst.
//   clk   in  clock
//   arst  in  asynchronous active-low reset
//   bus   slave side of mseq_burst_ctrl_if:
//           start/abort/div/len/seed/manch_en in,
//           busy/done/err/bit_out/bit_valid/line_out/sreg out
// -----------------------------------------------------------------------------
module mseq_burst_ctrl
  import mseq_pkg::*;
#(
  parameter int         W     = 8,
  parameter logic [W:0] POLY  = MSEQ_POLY_DEF,
  parameter int         DIV_W = 16,
  parameter int         LEN_W = 12
) (
  input  logic               clk,
  input  logic               arst,
  mseq_burst_ctrl_if.slave   bus
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  mseq_state_e      state_r;
  logic [DIV_W-1:0] hcnt_r;
  logic             phase_r;
  logic [LEN_W-1:0] bcnt_r;
  logic [DIV_W-1:0] div_q_r;
  logic [LEN_W-1:0] len_q_r;
  logic             manch_q_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic             start_ok_s;
  logic             half_end_s;
  logic             last_bit_s;
  logic             load_s;
  logic             step_s;
  logic             run_s;
  logic [W-1:0]     sreg_s;

  // Decode of the current half-period / bit position and LFSR controls
  always_comb begin
    start_ok_s = (bus.seed != {W{1'b0}}) && (bus.len != {LEN_W{1'b0}});
    half_end_s = (hcnt_r == div_q_r);
    last_bit_s = (bcnt_r == (len_q_r - LEN_ONE));
    run_s      = (state_r == RUN);
    load_s     = (state_r == IDLE) && bus.start && start_ok_s;
    // The final bit never steps: sreg keeps the state of the last bit sent.
    step_s     = run_s && !bus.abort && half_end_s && phase_r && !last_bit_s;
  end

  mseq_lfsr_core #(
    .W    (W),
    .POLY (POLY)
  ) u_lfsr (
    .clk      (clk),
    .arst     (arst),
    .load     (load_s),
    .load_val (bus.seed),
    .step     (step_s),
    .state    (sreg_s)
  );

  // Controller FSM with divider, bit counter and registered handshake outputs
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_r   <= IDLE;
      hcnt_r    <= {DIV_W{1'b0}};
      phase_r   <= 1'b0;
      bcnt_r    <= {LEN_W{1'b0}};
      div_q_r   <= {DIV_W{1'b0}};
      len_q_r   <= {LEN_W{1'b0}};
      manch_q_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          // start beats a simultaneous abort: abort is only looked at in RUN.
          if (bus.start && start_ok_s) begin
            state_r   <= RUN;
            hcnt_r    <= {DIV_W{1'b0}};
            phase_r   <= 1'b0;
            bcnt_r    <= {LEN_W{1'b0}};
            div_q_r   <= bus.div;
            len_q_r   <= bus.len;
            manch_q_r <= bus.manch_en;
            busy_r    <= 1'b1;
            err_r     <= 1'b0;
          end else if (bus.start) begin
            err_r <= 1'b1;
          end else begin
            err_r <= 1'b0;
          end
        end
        RUN: begin
          err_r  <= 1'b0;
          done_r <= 1'b0;
          if (bus.abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (half_end_s) begin
            hcnt_r  <= {DIV_W{1'b0}};
            phase_r <= ~phase_r;
            if (phase_r && last_bit_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else if (phase_r) begin
              bcnt_r <= bcnt_r + LEN_ONE;
            end else begin
              bcnt_r <= bcnt_r;
            end
          end else begin
            hcnt_r <= hcnt_r + DIV_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Status and line encoder, decoded from registers only
  always_comb begin
    bus.busy      = busy_r;
    bus.done      = done_r;
    bus.err       = err_r;
    bus.sreg      = sreg_s;
    bus.bit_out   = sreg_s[0];
    bus.bit_valid = run_s && !phase_r && (hcnt_r == {DIV_W{1'b0}});
    if (run_s && manch_q_r) begin
      // First half carries the inverted bit when '1' is sent low->high.
      bus.line_out = sreg_s[0] ^ (MANCH_LOW_HIGH ^ phase_r);
    end else if (run_s) begin
      bus.line_out = sreg_s[0];
    end else begin
      bus.line_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_mseq_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mseq_burst_ctrl
// Directed bench for mseq_burst_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mseq_burst_ctrl;

  logic clk;
  logic arst;

  mseq_burst_ctrl_if #(.W(8), .DIV_W(16), .LEN_W(12)) bus ();

  mseq_burst_ctrl #(
    .W     (8),
    .POLY  (9'h11D),
    .DIV_W (16),
    .LEN_W (12)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start; returns at the falling edge of the first RUN cycle.
  task automatic go(input logic [7:0] seed, input logic [11:0] len,
                    input logic [15:0] div, input logic manch);
    bus.seed     = seed;
    bus.len      = len;
    bus.div      = div;
    bus.manch_en = manch;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  logic [7:0] gold;
  logic [7:0] man;
  int ones;
  int busy_cnt;
  int k;

  initial begin
    arst         = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.div      = 16'd0;
    bus.len      = 12'd0;
    bus.seed     = 8'd0;
    bus.manch_en = 1'b0;
    gold         = 8'h8D;   // bits in send order (LSB first): 1,0,1,1,0,0,0,1
    man          = 8'h3C;   // line_out per cycle (LSB first): 0,0,1,1,1,1,0,0

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);
    chk("rst_err",   32'(bus.err),       32'd0);
    chk("rst_valid", 32'(bus.bit_valid), 32'd0);
    chk("rst_line",  32'(bus.line_out),  32'd0);
    chk("rst_sreg",  32'(bus.sreg),      32'h01);
    arst = 1'b1;
    @(negedge clk);

    // NRZ golden sequence; a start with other settings mid-burst is ignored
    go(8'h01, 12'd8, 16'd0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      chk("nrz_bit",   32'(bus.bit_out),   32'(gold[c/2]));
      chk("nrz_line",  32'(bus.line_out),  32'(gold[c/2]));
      chk("nrz_valid", 32'(bus.bit_valid), 32'((c % 2) == 0));
      chk("nrz_busy",  32'(bus.busy),      32'd1);
      if (c == 4) begin
        bus.start    = 1'b1;
        bus.len      = 12'd3;
        bus.div      = 16'd5;
        bus.seed     = 8'h55;
        bus.manch_en = 1'b1;
      end
      if (c == 5) bus.start = 1'b0;
      @(negedge clk);
    end
    chk("nrz_done",      32'(bus.done),     32'd1);
    chk("nrz_done_busy", 32'(bus.busy),     32'd0);
    chk("nrz_done_line", 32'(bus.line_out), 32'd0);
    chk("nrz_sreg",      32'(bus.sreg),     32'h1B);
    @(negedge clk);
    chk("nrz_done_pulse", 32'(bus.done), 32'd0);

    // Manchester, div=1, two bits
    go(8'h01, 12'd2, 16'd1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("man_line", 32'(bus.line_out), 32'(man[c]));
      chk("man_busy", 32'(bus.busy),     32'd1);
      @(negedge clk);
    end
    chk("man_done",      32'(bus.done),     32'd1);
    chk("man_done_busy", 32'(bus.busy),     32'd0);
    chk("man_done_line", 32'(bus.line_out), 32'd0);
    @(negedge clk);

    // Full period: 255 bits, 128 ones, ends on the predecessor of the seed
    go(8'h01, 12'd255, 16'd0, 1'b0);
    ones = 0;
    busy_cnt = 0;
    k = 0;
    while (!bus.done && k < 2000) begin
      if (bus.busy) busy_cnt++;
      if (bus.bit_valid && bus.bit_out) ones++;
      @(negedge clk);
      k++;
    end
    chk("fp_timeout", 32'(k < 2000), 32'd1);
    chk("fp_ones",    32'(ones),     32'd128);
    chk("fp_busy",    32'(busy_cnt), 32'd510);
    chk("fp_sreg",    32'(bus.sreg), 32'h02);
    @(negedge clk);

    // Rejected starts: seed==0 then len==0
    bus.seed  = 8'h00;
    bus.len   = 12'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rej_seed_err",  32'(bus.err),  32'd1);
    chk("rej_seed_busy", 32'(bus.busy), 32'd0);
    chk("rej_seed_sreg", 32'(bus.sreg), 32'h02);
    @(negedge clk);
    chk("rej_err_pulse", 32'(bus.err),  32'd0);
    chk("rej_idle_busy", 32'(bus.busy), 32'd0);
    bus.seed  = 8'h05;
    bus.len   = 12'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rej_len_err",  32'(bus.err),  32'd1);
    chk("rej_len_busy", 32'(bus.busy), 32'd0);
    chk("rej_len_sreg", 32'(bus.sreg), 32'h02);
    @(negedge clk);

    // Abort on bit 3 (RUN cycle 6)
    go(8'h01, 12'd8, 16'd0, 1'b0);
    repeat (6) @(negedge clk);
    chk("abt_pre_sreg",  32'(bus.sreg),      32'hAD);
    chk("abt_pre_valid", 32'(bus.bit_valid), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abt_busy", 32'(bus.busy),     32'd0);
    chk("abt_line", 32'(bus.line_out), 32'd0);
    chk("abt_sreg", 32'(bus.sreg),     32'hAD);
    for (int c = 0; c < 3; c++) begin
      chk("abt_no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    chk("abt_frozen", 32'(bus.sreg), 32'hAD);

    // Start and abort together in IDLE: the burst starts
    bus.seed     = 8'h01;
    bus.len      = 12'd1;
    bus.div      = 16'd0;
    bus.manch_en = 1'b0;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy", 32'(bus.busy),    32'd1);
    chk("sa_bit",  32'(bus.bit_out), 32'd1);
    @(negedge clk);
    chk("sa_busy2", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("sa_done", 32'(bus.done), 32'd1);
    chk("sa_sreg", 32'(bus.sreg), 32'h01);
    @(negedge clk);

    // Reset mid-burst, then a fresh burst
    go(8'h01, 12'd8, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    arst = 1'b0;
    #1;
    chk("mrst_busy",  32'(bus.busy),      32'd0);
    chk("mrst_sreg",  32'(bus.sreg),      32'h01);
    chk("mrst_valid", 32'(bus.bit_valid), 32'd0);
    chk("mrst_line",  32'(bus.line_out),  32'd0);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    go(8'h47, 12'd2, 16'd0, 1'b0);
    chk("post_bit",  32'(bus.bit_out), 32'd1);
    chk("post_sreg", 32'(bus.sreg),    32'h47);
    repeat (2) @(negedge clk);
    chk("post_sreg2", 32'(bus.sreg), 32'hAD);
    chk("post_busy",  32'(bus.busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("post_done",  32'(bus.done), 32'd1);
    chk("post_final", 32'(bus.sreg), 32'hAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
